// File: rtl/light_pkg.sv
// Shared time-of-day and debouncer definitions for the light-controller stimulus block.
// Window bounds live here so the controller and this source agree on the active hours.
package light_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;

  localparam int WIN_START_HOUR = 20;
  localparam int WIN_END_HOUR   = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } dbc_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
  } tod_t;

  // Full 5-bit compare: a 4-bit window would alias hours 4..7 onto 20..23.
  function automatic logic hour_in_window(logic [HOUR_W-1:0] h,
                                          logic [HOUR_W-1:0] lo,
                                          logic [HOUR_W-1:0] hi);
    return (h >= lo) && (h <= hi);
  endfunction

endpackage

// File: rtl/light_time_source_if.sv
// Board-side bundle: raw button and hour-load request in, time of day and button events out.
// No handshake back-pressure; every output is a registered level or one-cycle pulse.
interface light_time_source_if;
  import light_pkg::*;

  logic              btn_raw;
  logic              set_valid;
  logic [HOUR_W-1:0] set_hour;
  logic [HOUR_W-1:0] hour;
  logic [MIN_W-1:0]  minute;
  logic [SEC_W-1:0]  second;
  logic              sec_tick;
  logic              in_window;
  logic              btn_pulse;
  logic              btn_level;
  logic              set_err;

  modport master (
    output btn_raw, set_valid, set_hour,
    input  hour, minute, second, sec_tick, in_window, btn_pulse, btn_level, set_err
  );

  modport slave (
    input  btn_raw, set_valid, set_hour,
    output hour, minute, second, sec_tick, in_window, btn_pulse, btn_level, set_err
  );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer plus press/release debouncer; pulse lands 2 + DEBOUNCE_TICKS cycles after a stable press.
// No back-pressure: emits one registered pulse per accepted press and never auto-repeats.
module btn_debounce
  import light_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_pulse_o
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_TICKS >= 2) ? CW'(DEBOUNCE_TICKS - 2) : '0;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_PRESS = PRESS_CHK;
  localparam logic [1:0] S_HELD  = HELD;
  localparam logic [1:0] S_REL   = REL_CHK;

  logic          sync1_q, sync_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          done;

  // The sample that moves the FSM out of IDLE/HELD is the first stable one, so the
  // counter holds "extra" samples and the run completes when it reaches D-2.
  assign done = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync_q) begin
          state_d = S_PRESS;
          cnt_d   = '0;
        end
      end
      S_PRESS: begin
        if (!sync_q) begin
          state_d = S_IDLE;
        end else if (done) begin
          state_d = S_HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (!sync_q) begin
          state_d = S_REL;
          cnt_d   = '0;
        end
      end
      S_REL: begin
        if (sync_q) begin
          state_d = S_HELD;
        end else if (done) begin
          state_d = S_IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level_o = level_q;
  assign btn_pulse_o = pulse_q;

endmodule

// File: rtl/light_time_source.sv
// Time-of-day counter with hour load and night-window flag, plus debounced mode button.
// Outputs are registered one cycle after the causing edge; there is no back-pressure.
module light_time_source
  import light_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int START_HOUR     = WIN_START_HOUR,
  parameter int END_HOUR       = WIN_END_HOUR
) (
  input logic               clk,
  input logic               rst_n,
  light_time_source_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [HOUR_W-1:0] START_H    = HOUR_W'(START_HOUR);
  localparam logic [HOUR_W-1:0] END_H      = HOUR_W'(END_HOUR);
  localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_MAX);

  logic [PW-1:0] presc_q, presc_d;
  tod_t          tod_q, tod_d;
  logic          sec_tick_q, sec_tick_d;
  logic          in_window_q, in_window_d;
  logic          set_err_q, set_err_d;
  logic          wrap, load_ok, load_bad;

  assign wrap     = (presc_q == PRESC_LAST);
  assign load_ok  = bus.set_valid && (bus.set_hour <= HOUR_LAST);
  assign load_bad = bus.set_valid && (bus.set_hour > HOUR_LAST);

  always_comb begin
    presc_d = wrap ? '0 : presc_q + 1'b1;
    tod_d   = tod_q;
    if (wrap) begin
      if (tod_q.second == SEC_LAST) begin
        tod_d.second = '0;
        if (tod_q.minute == MIN_LAST) begin
          tod_d.minute = '0;
          tod_d.hour   = (tod_q.hour == HOUR_LAST) ? '0 : tod_q.hour + 1'b1;
        end else begin
          tod_d.minute = tod_q.minute + 1'b1;
        end
      end else begin
        tod_d.second = tod_q.second + 1'b1;
      end
    end
    // A legal load overrides whatever the rollover would have produced.
    if (load_ok) begin
      presc_d      = '0;
      tod_d.hour   = bus.set_hour;
      tod_d.minute = '0;
      tod_d.second = '0;
    end
    sec_tick_d  = wrap && !load_ok;
    set_err_d   = load_bad;
    in_window_d = hour_in_window(tod_d.hour, START_H, END_H);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      tod_q       <= '0;
      sec_tick_q  <= 1'b0;
      in_window_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tod_q       <= tod_d;
      sec_tick_q  <= sec_tick_d;
      in_window_q <= in_window_d;
      set_err_q   <= set_err_d;
    end
  end

  assign bus.hour      = tod_q.hour;
  assign bus.minute    = tod_q.minute;
  assign bus.second    = tod_q.second;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.in_window = in_window_q;
  assign bus.set_err   = set_err_q;

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw_i  (bus.btn_raw),
    .btn_level_o(bus.btn_level),
    .btn_pulse_o(bus.btn_pulse)
  );

endmodule
